// File: rtl/xgriscv_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and access-legality helpers.
package xgriscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_STB  = 3'd3,
        ST_RESP = 3'd4
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only a half-word crossing the word boundary or an unaligned word needs splitting.
    function automatic logic f3_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == 2'b01) && (off == 2'b11)) || ((size == 2'b10) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/xgriscv_lsu_load_align.sv
// Shifts a (possibly two-word) read down to the byte offset and applies RV32I load extension.
module xgriscv_lsu_load_align
    import xgriscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2*XLEN-1:0] merged,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = XLEN'(merged >> {off, 3'b000});
        case (funct3)
            F3_B:    result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/xgriscv_lsu.sv
// Load/store unit: drives the word-addressed data-memory port, splitting misaligned accesses
// into two word reads (loads) or per-byte writes (stores).
module xgriscv_lsu
    import xgriscv_lsu_pkg::*;
#(
    parameter int unsigned XLEN             = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_we,
    output logic [3:0]      mem_amp,
    output logic [XLEN-1:0] mem_a,
    output logic [XLEN-1:0] mem_wd,
    input  logic [XLEN-1:0] mem_rd
);

    lsu_state_e      state, state_n;
    logic            we_q, we_n;
    logic [2:0]      f3_q, f3_n;
    logic [XLEN-1:0] addr_q, addr_n, wdata_q, wdata_n, lo_q, lo_n;
    logic [1:0]      cnt_q, cnt_n;

    logic            req_ready_n, resp_valid_n, resp_err_n, mem_we_n;
    logic [XLEN-1:0] resp_rdata_n, mem_a_n, mem_wd_n;
    logic [3:0]      mem_amp_n;

    logic [XLEN-1:0] cur_addr, cur_wdata, stb_addr, load_ext;
    logic [2*XLEN-1:0] merged;
    logic [1:0]      stb_idx, stb_last;
    logic [7:0]      stb_byte;
    logic            req_legal, req_mis, mis_q;
    logic [3:0]      st_amp;
    logic [XLEN-1:0] st_wd;

    // The byte-write stream is computed from the live request on accept, from the latches afterwards.
    always_comb begin
        cur_addr  = (state == ST_IDLE) ? req_addr : addr_q;
        cur_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
        stb_idx   = (state == ST_STB) ? cnt_q + 2'd1 : 2'd0;
        stb_addr  = cur_addr + XLEN'(stb_idx);
        stb_byte  = cur_wdata[{stb_idx, 3'b000} +: 8];
        stb_last  = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
        req_legal = f3_legal(req_we, req_funct3);
        req_mis   = f3_misaligned(req_funct3[1:0], req_addr[1:0]);
        mis_q     = f3_misaligned(f3_q[1:0], addr_q[1:0]);
        merged    = (state == ST_ACC1) ? {mem_rd, lo_q} : {{XLEN{1'b0}}, mem_rd};
    end

    // Aligned store lane mask and lane-replicated data.
    always_comb begin
        case (req_funct3[1:0])
            2'b10: begin
                st_amp = 4'b1111;
                st_wd  = req_wdata;
            end
            2'b01: begin
                st_amp = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wd  = {2{req_wdata[15:0]}};
            end
            default: begin
                st_amp = lane_onehot(req_addr[1:0]);
                st_wd  = {4{req_wdata[7:0]}};
            end
        endcase
    end

    xgriscv_lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .merged (merged),
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .result (load_ext)
    );

    // Next state plus next value of every registered output.
    always_comb begin
        state_n      = state;
        we_n         = we_q;
        f3_n         = f3_q;
        addr_n       = addr_q;
        wdata_n      = wdata_q;
        lo_n         = lo_q;
        cnt_n        = cnt_q;
        req_ready_n  = 1'b0;
        resp_valid_n = 1'b0;
        resp_rdata_n = '0;
        resp_err_n   = 1'b0;
        mem_we_n     = 1'b0;
        mem_amp_n    = 4'b0000;
        mem_a_n      = '0;
        mem_wd_n     = '0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    we_n    = req_we;
                    f3_n    = req_funct3;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    cnt_n   = 2'd0;
                    if (!req_legal || (req_mis && !ALLOW_MISALIGNED)) begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                    end else if (req_mis && req_we) begin
                        state_n   = ST_STB;
                        mem_we_n  = 1'b1;
                        mem_amp_n = lane_onehot(stb_addr[1:0]);
                        mem_a_n   = {stb_addr[XLEN-1:2], 2'b00};
                        mem_wd_n  = {4{stb_byte}};
                    end else begin
                        state_n = ST_ACC0;
                        mem_a_n = {req_addr[XLEN-1:2], 2'b00};
                        if (req_we) begin
                            mem_we_n  = 1'b1;
                            mem_amp_n = st_amp;
                            mem_wd_n  = st_wd;
                        end
                    end
                end else begin
                    req_ready_n = 1'b1;
                end
            end
            ST_ACC0: begin
                if (!we_q && mis_q) begin
                    lo_n    = mem_rd;
                    state_n = ST_ACC1;
                    mem_a_n = {addr_q[XLEN-1:2], 2'b00} + XLEN'(4);
                end else begin
                    state_n      = ST_RESP;
                    resp_valid_n = 1'b1;
                    resp_rdata_n = we_q ? '0 : load_ext;
                end
            end
            ST_ACC1: begin
                state_n      = ST_RESP;
                resp_valid_n = 1'b1;
                resp_rdata_n = load_ext;
            end
            ST_STB: begin
                if (cnt_q == stb_last) begin
                    state_n      = ST_RESP;
                    resp_valid_n = 1'b1;
                end else begin
                    cnt_n     = cnt_q + 2'd1;
                    mem_we_n  = 1'b1;
                    mem_amp_n = lane_onehot(stb_addr[1:0]);
                    mem_a_n   = {stb_addr[XLEN-1:2], 2'b00};
                    mem_wd_n  = {4{stb_byte}};
                end
            end
            ST_RESP: begin
                state_n     = ST_IDLE;
                req_ready_n = 1'b1;
            end
            default: begin
                state_n     = ST_IDLE;
                req_ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            cnt_q      <= 2'd0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_we     <= 1'b0;
            mem_amp    <= 4'b0000;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            state      <= state_n;
            we_q       <= we_n;
            f3_q       <= f3_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            lo_q       <= lo_n;
            cnt_q      <= cnt_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            mem_we     <= mem_we_n;
            mem_amp    <= mem_amp_n;
            mem_a      <= mem_a_n;
            mem_wd     <= mem_wd_n;
        end
    end

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Bench for xgriscv_lsu: word-addressed memory responder plus a byte-level reference model.
module tb_xgriscv_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_a, mem_wd, mem_rd;
    logic [3:0]  mem_amp;

    logic [31:0] mem [0:255];
    logic [7:0]  rmem [0:1023];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = 8'd0;
    logic [31:0] pl_data = 32'd0;
    logic [31:0] wlog_a[$];
    logic [3:0]  wlog_amp[$];
    logic [31:0] wlog_wd[$];

    int checks = 0;
    int errors = 0;
    int wstart, got_lat, got_nwr;
    logic [31:0] got_rdata, got_a1, got_a2;
    logic        got_err;

    always #5 clk = ~clk;

    xgriscv_lsu dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_amp(mem_amp), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = mem[mem_a[9:2]];

    // Memory responder: byte-lane writes on the clock edge, with a log of every write beat.
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            for (int l = 0; l < 4; l++)
                if (mem_amp[l]) mem[mem_a[9:2]][8*l +: 8] <= mem_wd[8*l +: 8];
            wlog_a.push_back(mem_a);
            wlog_amp.push_back(mem_amp);
            wlog_wd.push_back(mem_wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic ref_legal(input logic we, input logic [2:0] f3);
        if (we) return f3 inside {3'd0, 3'd1, 3'd2};
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        return (n == 2 && addr[1:0] == 2'd3) || (n == 4 && addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int n = nbytes(f3);
        logic [31:0] v = 32'd0;
        logic [31:0] ba;
        for (int i = 0; i < n; i++) begin
            ba = addr + 32'(i);
            v  = v | (32'(rmem[ba[9:0]]) << (8 * i));
        end
        if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
        if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    // An in-word half-word store uses the even half selected by addr[1].
    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        int n = nbytes(f3);
        logic [31:0] base = addr;
        logic [31:0] ba;
        if (n == 2 && !ref_mis(f3, addr)) base[0] = 1'b0;
        for (int i = 0; i < n; i++) begin
            ba = base + 32'(i);
            rmem[ba[9:0]] = wdata[8*i +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        wstart = wlog_a.size();
        @(posedge clk);
        #1 req_valid = 1'b0;
        got_lat = 0; got_rdata = 'x; got_err = 1'bx; got_a1 = 'x; got_a2 = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) got_a1 = mem_a;
            if (c == 2) got_a2 = mem_a;
            if (resp_valid) begin
                got_lat = c; got_rdata = resp_rdata; got_err = resp_err;
                break;
            end
        end
        got_nwr = wlog_a.size() - wstart;
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid), 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic check_req(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        logic e_err = !ref_legal(we, f3);
        logic mis = ref_mis(f3, addr);
        int n = nbytes(f3);
        int e_lat = e_err ? 1 : (we && mis) ? 1 + n : mis ? 3 : 2;
        int e_nwr = (e_err || !we) ? 0 : mis ? n : 1;
        logic [31:0] e_rd = (e_err || we) ? 32'd0 : ref_load(f3, addr);
        do_req(we, f3, addr, wdata);
        chk({tag, ".err"}, 32'(got_err), 32'(e_err));
        chk({tag, ".lat"}, 32'(got_lat), 32'(e_lat));
        chk({tag, ".nwr"}, 32'(got_nwr), 32'(e_nwr));
        chk({tag, ".rdata"}, got_rdata, e_rd);
        if (!e_err && we) ref_store(f3, addr, wdata);
    endtask

    initial begin
        logic [2:0] ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [31:0] exp_a [4] = '{32'h40, 32'h40, 32'h44, 32'h44};
        logic [3:0]  exp_amp [4] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [7:0]  exp_b [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        int seen, mism;
        logic we;
        logic [2:0] f3;

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 8'(i); pl_data = $urandom;
            for (int b = 0; b < 4; b++) rmem[4*i + b] = pl_data[8*b +: 8];
        end
        @(negedge clk);
        pl_en = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_amp", 32'(mem_amp), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        check_req("t1_sw", 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        chk("t1_wa", wlog_a[wstart], 32'h10);
        chk("t1_wamp", 32'(wlog_amp[wstart]), 32'hF);
        chk("t1_wwd", wlog_wd[wstart], 32'hDEADBEEF);
        check_req("t1_lw", 1'b0, 3'd2, 32'h10, 32'd0);
        chk("t1_lw_val", got_rdata, 32'hDEADBEEF);

        check_req("t2_sw", 1'b1, 3'd2, 32'h20, 32'h80FF7F01);
        check_req("t2_lb", 1'b0, 3'd0, 32'h22, 32'd0);
        chk("t2_lb_val", got_rdata, 32'hFFFFFFFF);
        check_req("t2_lbu", 1'b0, 3'd4, 32'h22, 32'd0);
        chk("t2_lbu_val", got_rdata, 32'h000000FF);
        check_req("t2_lh", 1'b0, 3'd1, 32'h22, 32'd0);
        chk("t2_lh_val", got_rdata, 32'hFFFF80FF);
        check_req("t2_lhu", 1'b0, 3'd5, 32'h20, 32'd0);
        chk("t2_lhu_val", got_rdata, 32'h00007F01);

        check_req("t3_sw0", 1'b1, 3'd2, 32'h30, 32'h44332211);
        check_req("t3_sw1", 1'b1, 3'd2, 32'h34, 32'h88776655);
        check_req("t3_lw", 1'b0, 3'd2, 32'h31, 32'd0);
        chk("t3_lw_val", got_rdata, 32'h55443322);
        chk("t3_lw_lat", 32'(got_lat), 32'd3);
        check_req("t3_lh", 1'b0, 3'd1, 32'h33, 32'd0);
        chk("t3_lh_val", got_rdata, 32'h00005544);

        check_req("t4_sw", 1'b1, 3'd2, 32'h42, 32'hA1B2C3D4);
        chk("t4_lat", 32'(got_lat), 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk("t4_wa", wlog_a[wstart + i], exp_a[i]);
            chk("t4_wamp", 32'(wlog_amp[wstart + i]), 32'(exp_amp[i]));
            chk("t4_wwd", wlog_wd[wstart + i], {4{exp_b[i]}});
        end
        chk("t4_mem40", 32'(mem[8'h10][31:16]), 32'hC3D4);
        chk("t4_mem44", 32'(mem[8'h11][15:0]), 32'hA1B2);

        check_req("t5_ld011", 1'b0, 3'd3, 32'h20, 32'd0);
        check_req("t5_st100", 1'b1, 3'd4, 32'h20, 32'h12345678);

        check_req("wrap_lw", 1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
        chk("wrap_a0", got_a1, 32'hFFFFFFFC);
        chk("wrap_a1", got_a2, 32'h00000000);
        check_req("wrap_sw", 1'b1, 3'd2, 32'hFFFFFFFF, 32'hCAFEF00D);
        check_req("sh_mis", 1'b1, 3'd1, 32'h57, 32'h0000BEEF);

        // Reset while the second byte of a split store is on the port.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h52; req_wdata = 32'h11223344;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t6_b0_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        chk("t6_b1_amp", 32'(mem_amp), 32'b1000);
        rstn = 1'b0;
        #1;
        chk("t6_rst_we", 32'(mem_we), 32'd0);
        chk("t6_rst_amp", 32'(mem_amp), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        rmem[10'h52] = 8'h44;
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        rstn = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("t6_no_resp", 32'(seen), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);

        for (int k = 0; k < 80; k++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else if (we) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_f3[$urandom_range(0, 4)];
            check_req("rnd", we, f3, $urandom, $urandom);
        end

        mism = 0;
        for (int w = 0; w < 256; w++)
            for (int b = 0; b < 4; b++)
                if (mem[w][8*b +: 8] !== rmem[4*w + b]) mism++;
        chk("mem_final", 32'(mism), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
